// File: rtl/seq_tx_pkg.sv
// ---------------------------------------------------------------------------
// seq_tx_pkg
// Shared types and helpers for the serial pattern transmitter.
//   state_t      : FSM state encoding (IDLE, SHIFT, GAP, DONE)
//   IDLE_LVL_DEF : default data_out level while not transmitting
//   clamp_len()  : maps a requested pattern length onto 1..width
// ---------------------------------------------------------------------------
package seq_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic IDLE_LVL_DEF = 1'b0;

   // A length of 0, or anything longer than the pattern register, means
   // "send the whole register".
   function automatic int clamp_len(input int len, input int width);
      return ((len == 0) || (len > width)) ? width : len;
   endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// ---------------------------------------------------------------------------
// seq_tx_shifter
// Loadable pattern register with a down-counting bit index. The pattern is
// held still; the index walks from L-1 down to 0 and the selected bits are
// presented to the FSM, which registers the one it actually emits.
// Build option: SEQ_TX_PARITY_EN adds an even-parity bit and a parity-phase
// flag marking the extra cycle at the end of each pass.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   load                  capture pattern_in / len_in, index <= len_in-1
//   restart               start another pass, index <= L-1
//   step                  move to the next lower bit (saturates at 0)
//   par_step              (parity build) enter the parity cycle
//   pattern_in, len_in    raw pattern and clamped length from the top
//   idx                   current bit index
//   load_bit              pattern_in[len_in-1] (first bit for a fresh load)
//   first_bit             stored pattern[L-1] (first bit of a repeat pass)
//   next_bit              stored pattern[idx-1] (bit after the current one)
//   par_bit, par_phase    (parity build) parity of the L bits, phase flag
// ---------------------------------------------------------------------------
module seq_tx_shifter
   import seq_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             restart,
   input  logic             step,
`ifdef SEQ_TX_PARITY_EN
   input  logic             par_step,
   output logic             par_bit,
   output logic             par_phase,
`endif
   input  logic [WIDTH-1:0] pattern_in,
   input  logic [LEN_W-1:0] len_in,
   output logic [LEN_W-1:0] idx,
   output logic             load_bit,
   output logic             first_bit,
   output logic             next_bit
);

   logic [WIDTH-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] idx_q;

   // Bit select by a run-time index; out-of-range indices read as 0.
   function automatic logic sel_bit(input logic [WIDTH-1:0] v,
                                    input logic [LEN_W-1:0] i);
      logic b;
      b = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         if (i == LEN_W'(k)) b = v[k];
      end
      return b;
   endfunction

   assign idx       = idx_q;
   assign load_bit  = sel_bit(pattern_in, len_in - LEN_W'(1));
   assign first_bit = sel_bit(pat_q, len_q - LEN_W'(1));
   assign next_bit  = sel_bit(pat_q, idx_q - LEN_W'(1));

`ifdef SEQ_TX_PARITY_EN
   logic par_q;
   logic phase_q;
   logic load_par;

   // (1 << L) - 1 wraps to all-ones when L == WIDTH, masking every bit.
   assign load_par  = ^(pattern_in & ((WIDTH'(1) << len_in) - WIDTH'(1)));
   assign par_bit   = par_q;
   assign par_phase = phase_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q   <= 1'b0;
         phase_q <= 1'b0;
      end else if (load) begin
         par_q   <= load_par;
         phase_q <= 1'b0;
      end else if (restart) begin
         phase_q <= 1'b0;
      end else if (par_step) begin
         phase_q <= 1'b1;
      end
   end
`endif

   // NOTE: the pattern register is reset along with the counters so the
   // block comes out of reset fully deterministic; it is small enough that
   // leaving it unreset buys nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q <= '0;
         len_q <= '0;
         idx_q <= '0;
      end else if (load) begin
         pat_q <= pattern_in;
         len_q <= len_in;
         idx_q <= len_in - LEN_W'(1);
      end else if (restart) begin
         idx_q <= len_q - LEN_W'(1);
      end else if (step && (idx_q != '0)) begin
         idx_q <= idx_q - LEN_W'(1);
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
// Serial bit-pattern transmitter. A start captures pattern, length and
// repeat count; the pattern is then sent MSB-first one bit per clock for
// repeat_cnt+1 passes, with GAP_CYCLES idle cycles between passes, followed
// by a one-cycle done pulse. abort returns to IDLE on the next edge.
// Build option: SEQ_TX_PARITY_EN appends an even-parity bit to every pass.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_valid     start request; accepted when start_ready is high
//   start_ready     high only in IDLE
//   pattern         bits to send (low pat_len bits used)
//   pat_len         bits per pass; 0 or > WIDTH means WIDTH
//   repeat_cnt      extra passes
//   abort           synchronous abort (ignored in IDLE)
//   data_out        registered serial bit, IDLE_LVL when not sending
//   data_out_valid  high while data_out carries a pattern bit
//   busy            high in every non-IDLE state
//   done            one-cycle pulse after the final bit
// ---------------------------------------------------------------------------
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   LEN_W      = 4,
   parameter int   REP_W      = 4,
   parameter int   GAP_CYCLES = 2,
   parameter logic IDLE_LVL   = IDLE_LVL_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic [REP_W-1:0] repeat_cnt,
   input  logic             abort,
   output logic             data_out,
   output logic             data_out_valid,
   output logic             busy,
   output logic             done
);

   // Keeps the gap counter at least one bit wide when GAP_CYCLES is 0.
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   state_t           state_q, state_d;
   logic [REP_W-1:0] pass_q, pass_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             dout_q, dout_d;

   logic [LEN_W-1:0] len_in;
   logic [LEN_W-1:0] idx;
   logic             ld, restart, step;
   logic             load_bit, first_bit, next_bit;
`ifdef SEQ_TX_PARITY_EN
   logic             par_step, par_bit, par_phase;
`endif

   assign len_in = LEN_W'(clamp_len(int'(pat_len), WIDTH));

   seq_tx_shifter #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .load       (ld),
      .restart    (restart),
      .step       (step),
`ifdef SEQ_TX_PARITY_EN
      .par_step   (par_step),
      .par_bit    (par_bit),
      .par_phase  (par_phase),
`endif
      .pattern_in (pattern),
      .len_in     (len_in),
      .idx        (idx),
      .load_bit   (load_bit),
      .first_bit  (first_bit),
      .next_bit   (next_bit)
   );

   // NOTE: every signal is given a default before the case statement so no
   // path through this block leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d  = state_q;
      pass_d   = pass_q;
      gap_d    = gap_q;
      dout_d   = IDLE_LVL;
      ld       = 1'b0;
      restart  = 1'b0;
      step     = 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_step = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            // start_ready is high throughout IDLE, so start_valid alone
            // accepts; abort has no effect here.
            if (start_valid) begin
               state_d = SHIFT;
               ld      = 1'b1;
               pass_d  = repeat_cnt;
               dout_d  = load_bit;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (idx != '0) begin
               step   = 1'b1;
               dout_d = next_bit;
`ifdef SEQ_TX_PARITY_EN
            end else if (!par_phase) begin
               par_step = 1'b1;
               dout_d   = par_bit;
`endif
            end else if (pass_q != '0) begin
               if (GAP_CYCLES == 0) begin
                  restart = 1'b1;
                  pass_d  = pass_q - REP_W'(1);
                  dout_d  = first_bit;
               end else begin
                  state_d = GAP;
                  gap_d   = GAP_W'(GAP_CYCLES);
               end
            end else begin
               state_d = DONE;
            end
         end
         GAP: begin
            if (abort) begin
               state_d = IDLE;
               gap_d   = '0;
            end else if (gap_q <= GAP_W'(1)) begin
               state_d = SHIFT;
               restart = 1'b1;
               gap_d   = '0;
               dout_d  = first_bit;
               if (pass_q != '0) pass_d = pass_q - REP_W'(1);
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         DONE: begin
            // An abort seen here changes nothing: the pulse is already out.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pass_q  <= '0;
         gap_q   <= '0;
         dout_q  <= IDLE_LVL;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         gap_q   <= gap_d;
         dout_q  <= dout_d;
      end
   end

   assign data_out       = dout_q;
   assign data_out_valid = (state_q == SHIFT);
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
   assign start_ready    = (state_q == IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
// Directed bench for seq_pattern_tx. Expected bits are queued when a start is
// issued; a monitor pops and compares on every cycle with data_out_valid.
// Timing (done cycle, busy length, valid/gap shape) is checked per run.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

   localparam int W = 8;
   localparam int G = 2;
`ifdef SEQ_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_valid = 1'b0;
   logic       start_ready;
   logic [7:0] pattern = '0;
   logic [3:0] pat_len = '0;
   logic [3:0] repeat_cnt = '0;
   logic       abort = 1'b0;
   logic       data_out;
   logic       data_out_valid;
   logic       busy;
   logic       done;

   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   seq_pattern_tx #(
      .WIDTH      (W),
      .LEN_W      (4),
      .REP_W      (4),
      .GAP_CYCLES (G),
      .IDLE_LVL   (1'b0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_valid    (start_valid),
      .start_ready    (start_ready),
      .pattern        (pattern),
      .pat_len        (pat_len),
      .repeat_cnt     (repeat_cnt),
      .abort          (abort),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .busy           (busy),
      .done           (done)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every valid bit must match the head of the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (data_out_valid) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
            else check("sb_bit", 32'(data_out), 32'(exp_q.pop_front()));
         end
      end
   end

   function automatic int clampl(input int len);
      return (len == 0 || len > W) ? W : len;
   endfunction

   // Queue the expected bits of a full transmission.
   task automatic push_tx(input logic [7:0] pat, input int len, input int rep);
      int   l;
      logic p;
      l = clampl(len);
      for (int r = 0; r <= rep; r++) begin
         p = 1'b0;
         for (int b = l - 1; b >= 0; b--) begin
            exp_q.push_back(pat[b]);
            p ^= pat[b];
         end
         if (PAR != 0) exp_q.push_back(p);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!start_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!start_ready) check("ready_timeout", 32'(start_ready), 1);
   endtask

   // One complete transmission with timing checks. exp_det >= 0 also checks
   // the number of overlapping 101 detections seen on data_out.
   task automatic run_tx(input string name, input logic [7:0] pat,
                         input int len, input int rep, input logic ab,
                         input int exp_det);
      int          l, p, t, c, busy_n, done_at, idle_bad, det, d0;
      logic [31:0] vexp, vact;
      logic [2:0]  sh;
      logic        rdy_after;
      l = clampl(len);
      p = l + PAR;
      t = (rep + 1) * p + rep * G + 1;
      vexp = '0;
      c = 1;
      for (int r = 0; r <= rep; r++) begin
         for (int k = 0; k < p; k++) begin
            vexp[c] = 1'b1;
            c++;
         end
         if (r < rep) c += G;
      end
      wait_ready();
      push_tx(pat, len, rep);
      pattern     = pat;
      pat_len     = 4'(len);
      repeat_cnt  = 4'(rep);
      abort       = ab;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      abort       = 1'b0;
      d0 = done_cnt;
      vact = '0; busy_n = 0; done_at = 0; idle_bad = 0; det = 0; sh = '0;
      rdy_after = 1'b0;
      for (int i = 1; i <= t + 3; i++) begin
         @(negedge clk);
         vact[i] = data_out_valid;
         if (busy) busy_n++;
         if (!data_out_valid && data_out !== 1'b0) idle_bad++;
         if (done && done_at == 0) done_at = i;
         if (i == t + 1) rdy_after = start_ready;
         sh = {sh[1:0], data_out};
         if (sh == 3'b101) det++;
      end
      @(posedge clk);
      #1;
      check({name, "_done_cycle"}, 32'(done_at), 32'(t));
      check({name, "_busy_cycles"}, 32'(busy_n), 32'(t));
      check({name, "_valid_shape"}, vact, vexp);
      check({name, "_idle_level"}, 32'(idle_bad), 0);
      check({name, "_done_pulses"}, 32'(done_cnt - d0), 1);
      check({name, "_ready_after"}, 32'(rdy_after), 1);
      check({name, "_sb_drained"}, 32'(exp_q.size()), 0);
      if (exp_det >= 0) check({name, "_detections"}, 32'(det), 32'(exp_det));
   endtask

   initial begin
      int first, second, acc, d0, t;

      // Reset state, before any clock edge.
      #2;
      check("rst_ready", 32'(start_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(data_out_valid), 0);
      check("rst_done", 32'(done), 0);
      check("rst_dout", 32'(data_out), 0);
      #10;
      rst = 1'b0;

      // 101 x3 with gaps: done on cycle 14, three 101 detections.
      run_tx("rep101", 8'b0000_0101, 3, 2, 1'b0, (PAR == 0) ? 3 : -1);
      // pat_len 0 clamps to 8: 1,0,1,0,0,1,0,1 then done, busy 9 cycles.
      run_tx("len0", 8'hA5, 0, 0, 1'b0, -1);
      // pat_len above WIDTH also clamps to 8; two passes.
      run_tx("len12", 8'h3C, 12, 1, 1'b0, -1);
      // abort together with start in IDLE: start wins.
      run_tx("abort_start", 8'b0000_0010, 2, 0, 1'b1, -1);
      // Parity vectors (parity bit appended only in the parity build).
      run_tx("par101", 8'b0000_0101, 3, 0, 1'b0, -1);
      run_tx("par100", 8'b0000_0100, 3, 0, 1'b0, -1);

      // Abort on the 2nd bit of pass 1.
      wait_ready();
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      pattern = 8'hA5; pat_len = 4'd8; repeat_cnt = 4'd1; start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_valid", 32'(data_out_valid), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_dout", 32'(data_out), 0);
      @(negedge clk);
      check("abort_ready", 32'(start_ready), 1);
      repeat (20) @(negedge clk);
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt - d0), 0);
      check("abort_sb_drained", 32'(exp_q.size()), 0);

      // Reset during pass 2: outputs clear with no clock edge.
      wait_ready();
      push_tx(8'b0000_0101, 3, 2);
      pattern = 8'b0000_0101; pat_len = 4'd3; repeat_cnt = 4'd2;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (7) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(data_out_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_ready", 32'(start_ready), 1);
      check("mid_rst_dout", 32'(data_out), 0);
      check("mid_rst_done", 32'(done), 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(start_ready), 1);

      // start_valid held high: second accept T+1 edges after the first.
      t = 2 + PAR + 1;
      push_tx(8'h03, 2, 0);
      push_tx(8'h03, 2, 0);
      pattern = 8'h03; pat_len = 4'd2; repeat_cnt = 4'd0; start_valid = 1'b1;
      acc = 0; first = -1; second = -1;
      for (int c = 0; c < 40 && acc < 2; c++) begin
         if (c > 0) @(negedge clk);
         if (start_valid && start_ready) begin
            acc++;
            if (acc == 1) first = c;
            else second = c;
         end
      end
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      check("b2b_accepts", 32'(acc), 2);
      check("b2b_spacing", 32'(second - first), 32'(t + 1));
      repeat (t + 3) @(negedge clk);
      @(posedge clk);
      #1;
      check("b2b_sb_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial bit-pattern transmitter. Software or a stimulus block loads an N-bit pattern, a bit length and a repeat count; the block shifts the pattern out one bit per clock, MSB-first.
- It is the source side of the team's serial sequence detectors: its data_out drives a detector's data_in, for example the 101 Moore detector.
- Supports programmable inter-pass gaps, abort and a completion pulse.

Parameters:
- WIDTH, 8: maximum pattern length in bits.
- LEN_W, 4: width of pat_len; must satisfy 2^LEN_W > WIDTH.
- REP_W, 4: width of repeat_cnt.
- GAP_CYCLES, 2: idle cycles inserted between passes; 0 means no gap.
- IDLE_LVL, 1'b0: data_out level when not transmitting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start_valid  in  1  request to start a transmission.
- start_ready  out  1  high only in IDLE; a start is accepted when start_valid and start_ready are both high.
- pattern  in  WIDTH  bits to send; the low pat_len bits are used.
- pat_len  in  LEN_W  bits per pass; 0 or values above WIDTH are clamped to WIDTH.
- repeat_cnt  in  REP_W  extra passes; total passes = repeat_cnt+1.
- abort  in  1  synchronous abort request.
- data_out  out  1  serial bit, registered.
- data_out_valid  out  1  high while data_out carries a pattern bit.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse after the last bit of the last pass.

Behaviour:
- Reset (async, any state): state=IDLE, data_out=IDLE_LVL, data_out_valid=0, busy=0, done=0, start_ready=1, all counters=0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - On an accepting edge, capture pattern, clamped pat_len (L) and repeat_cnt into internal registers, then go to SHIFT.
  - Inputs are not sampled again until the next IDLE.
- SHIFT:
  - On the edge after acceptance, data_out = pattern[L-1] and data_out_valid=1. Latency is 1 cycle from the accept edge.
  - Each following edge emits the next lower bit, down to bit 0. A pass lasts L cycles.
  - After bit 0: if passes remain, go to GAP (or straight back to SHIFT, restarting at bit L-1, when GAP_CYCLES=0); otherwise go to DONE.
- GAP:
  - Lasts exactly GAP_CYCLES cycles with data_out=IDLE_LVL and data_out_valid=0.
  - Then returns to SHIFT, restarting at bit L-1, with the pass counter decremented.
- DONE:
  - Lasts one cycle: done=1, data_out=IDLE_LVL, data_out_valid=0.
  - Then IDLE; start_ready rises in the cycle after done.
- Back-to-back starts: minimum spacing between accept edges is the total transmit time plus 2 cycles. No start is accepted while busy.
- abort:
  - Sampled in SHIFT, GAP or DONE. The next edge forces IDLE; data_out returns to IDLE_LVL and data_out_valid to 0.
  - No done pulse is produced, except that an abort seen in DONE leaves that done pulse intact.
  - abort is ignored in IDLE. If abort and start_valid arrive together in IDLE, the start is accepted.
- Counters:
  - Bit index counter LEN_W wide; pass counter REP_W wide; gap counter sized with $clog2(GAP_CYCLES+1).
  - No wrap-around: all counters saturate at 0.
- Total busy cycles = (repeat_cnt+1)*L + repeat_cnt*GAP_CYCLES + 1.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined: after bit 0 of every pass, one extra SHIFT cycle emits the even-parity bit (XOR of the L transmitted bits) with data_out_valid=1. A pass becomes L+1 cycles and the busy-cycle formula uses L+1.
- Not defined: no parity cycle; parity logic is absent.

Decomposition:
- Package seq_tx_pkg:
  - state enum (IDLE, SHIFT, GAP, DONE);
  - localparam for default IDLE_LVL;
  - function clamp_len(pat_len, WIDTH).
- Sub-module seq_tx_shifter: loadable WIDTH-bit shift register with bit index output and optional parity accumulator. The top level holds the FSM, pass counter and gap counter.

Test Plan:
- Reset mid-transmission: assert rst during pass 2 → all outputs return to reset values asynchronously, with no clock edge needed; start_ready=1.
- pattern=8'b0000_0101, pat_len=3, repeat_cnt=2, GAP_CYCLES=2 → data_out/data_out_valid = 1,0,1 (valid), gap x2 (valid=0), 1,0,1, gap x2, 1,0,1. done pulses on cycle 14 after accept. Driving the 101 detector yields exactly 3 detections.
- pat_len=0, pattern=8'hA5, repeat_cnt=0 → 8 bits 1,0,1,0,0,1,0,1, then done; busy high for exactly 9 cycles.
- abort on the 2nd bit of pass 1 → next cycle IDLE, data_out_valid=0, done never pulses; start_ready=1 the following cycle.
- start_valid held high throughout → second accept occurs only after done plus 1 cycle; no overlap of data_out_valid between runs.
- SEQ_TX_PARITY_EN defined, pattern=3'b101, pat_len=3 → bits 1,0,1,0 (parity=0); with pattern=3'b100 → bits 1,0,0,1.
